// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and colour type.
// Timing defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    localparam int unsigned FB_W  = 160;
    localparam int unsigned FB_H  = 120;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned FB_AW = 15;

    typedef logic [7:0] rgb332_t;

    // y*160 + x built from shifts: 160 = 128 + 32
    function automatic logic [FB_AW-1:0] fb_index(input logic [FB_AW-1:0] x,
                                                  input logic [FB_AW-1:0] y);
        return (y << 7) + (y << 5) + x;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, raster counters, raw sync/active decode and the
// start-of-vertical-blanking tick.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_active,
    output logic             o_hs_raw,
    output logic             o_vs_raw,
    output logic             o_frame_tick
);

    localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic             r_pix_ph;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             r_frame_tick;
    logic             w_line_end;
    logic             w_frame_end;

    assign w_line_end  = (r_hcnt == CNT_W'(H_TOT - 1));
    assign w_frame_end = (r_vcnt == CNT_W'(V_TOT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_ph     <= 1'b0;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pix_ph     <= ~r_pix_ph;
            r_frame_tick <= r_pix_ph && w_line_end && (r_vcnt == CNT_W'(V_ACTIVE - 1));
            if (r_pix_ph) begin
                if (w_line_end) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_frame_end ? '0 : r_vcnt + CNT_W'(1);
                end else begin
                    r_hcnt <= r_hcnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_pix_en     = r_pix_ph;
    assign o_hcnt       = r_hcnt;
    assign o_vcnt       = r_vcnt;
    assign o_active     = (r_hcnt < CNT_W'(H_ACTIVE)) && (r_vcnt < CNT_W'(V_ACTIVE));
    assign o_hs_raw     = !((r_hcnt >= CNT_W'(HS_START)) && (r_hcnt < CNT_W'(HS_END)));
    assign o_vs_raw     = !((r_vcnt >= CNT_W'(VS_START)) && (r_vcnt < CNT_W'(VS_END)));
    assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/vga_ctrl.sv
// VGA controller: 160x120 RGB332 framebuffer scaled 4x to the raster.
// Define VGA_BORDER_EN to overlay BORDER_COLOR on the framebuffer edge pixels.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_FP         = H_FP_DEF,
    parameter int unsigned H_SYNC       = H_SYNC_DEF,
    parameter int unsigned H_BP         = H_BP_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_FP         = V_FP_DEF,
    parameter int unsigned V_SYNC       = V_SYNC_DEF,
    parameter int unsigned V_BP         = V_BP_DEF,
    parameter rgb332_t     BORDER_COLOR = 8'hFF
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] fb_addr,
    input  logic [7:0]  fb_data,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [1:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_tick
);

    logic             w_pix_en;
    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_active;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic [FB_AW-1:0] w_fb_x;
    logic [FB_AW-1:0] w_fb_y;
    rgb332_t          w_pix;

    logic [FB_AW-1:0] r_fb_addr;
    logic             r_active_d;
    logic             r_hs_d;
    logic             r_vs_d;
    rgb332_t          r_rgb;
    logic             r_hs;
    logic             r_vs;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .o_pix_en     (w_pix_en),
        .o_hcnt       (w_hcnt),
        .o_vcnt       (w_vcnt),
        .o_active     (w_active),
        .o_hs_raw     (w_hs_raw),
        .o_vs_raw     (w_vs_raw),
        .o_frame_tick (frame_tick)
    );

    assign w_fb_x = FB_AW'(w_hcnt >> 2);
    assign w_fb_y = FB_AW'(w_vcnt >> 2);

`ifdef VGA_BORDER_EN
    logic r_border_d;
    logic w_border;

    assign w_border = (w_fb_x == '0) || (w_fb_x == FB_AW'(FB_W - 1)) ||
                      (w_fb_y == '0) || (w_fb_y == FB_AW'(FB_H - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_border_d <= 1'b0;
        else if (w_pix_en)
            r_border_d <= w_border;
    end

    assign w_pix = r_border_d ? BORDER_COLOR : fb_data;
`else
    assign w_pix = fb_data;
`endif

    // Stage 1 issues the fetch; stage 2 consumes fb_data two clocks later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fb_addr  <= '0;
            r_active_d <= 1'b0;
            r_hs_d     <= 1'b1;
            r_vs_d     <= 1'b1;
            r_rgb      <= '0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
        end else if (w_pix_en) begin
            if (w_active)
                r_fb_addr <= fb_index(w_fb_x, w_fb_y);
            r_active_d <= w_active;
            r_hs_d     <= w_hs_raw;
            r_vs_d     <= w_vs_raw;
            r_rgb      <= r_active_d ? w_pix : '0;
            r_hs       <= r_hs_d;
            r_vs       <= r_vs_d;
        end
    end

    assign fb_addr   = r_fb_addr;
    assign {r, g, b} = r_rgb;
    assign hs        = r_hs;
    assign vs        = r_vs;

endmodule

// File: tb/tb_vga_ctrl.sv
// Scoreboard bench for vga_ctrl on a reduced raster; expected pixels are
// pushed per counter step and popped two pixel periods later.
module tb_vga_ctrl;

    localparam int unsigned HA = 64, HF = 4, HSW = 8, HB = 4;
    localparam int unsigned VA = 16, VF = 2, VSW = 2, VB = 4;
    localparam int unsigned HT = HA + HF + HSW + HB;
    localparam int unsigned VT = VA + VF + VSW + VB;
    localparam int unsigned FRAME_CLK = 2 * HT * VT;
    localparam logic [7:0]  BC = 8'hFF;

    typedef struct {
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        int unsigned h;
        int unsigned v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data;
    logic [2:0]  r, g;
    logic [1:0]  b;
    logic        hs, vs, frame_tick;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned mode = 0;
    exp_t        sb[$];
    int unsigned mh, mv, clkcnt;
    logic        prev_hs, prev_vs;
    int unsigned hs_fall_t, vs_fall_t, ft_t, ft_cnt;
    logic        hs_fall_ok, vs_fall_ok, ft_ok;

    vga_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .BORDER_COLOR (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .r          (r),
        .g          (g),
        .b          (b),
        .hs         (hs),
        .vs         (vs),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fb_model(input logic [14:0] a);
        case (mode)
            0:       return a[7:0];
            1:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) fb_data <= fb_model(fb_addr);

    function automatic exp_t expect_at(input int unsigned h, input int unsigned v);
        exp_t e;
        int unsigned x, y;
        x = h / 4;
        y = v / 4;
        e.h   = h;
        e.v   = v;
        e.hs  = !(h >= HA + HF && h < HA + HF + HSW);
        e.vs  = !(v >= VA + VF && v < VA + VF + VSW);
        e.rgb = 8'h00;
        if (h < HA && v < VA) begin
            e.rgb = fb_model(15'(y * 160 + x));
`ifdef VGA_BORDER_EN
            if (x == 0 || x == 159 || y == 0 || y == 119)
                e.rgb = BC;
`endif
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        check({tag, "_hs"}, 32'(hs), 32'd1);
        check({tag, "_vs"}, 32'(vs), 32'd1);
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    endtask

    // Called with clk low just after rst is released.
    task automatic sb_restart();
        sb.delete();
        mh = 0;
        mv = 0;
        clkcnt = 0;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        hs_fall_ok = 1'b0;
        vs_fall_ok = 1'b0;
        ft_ok = 1'b0;
        ft_cnt = 0;
        sb.push_back(expect_at(0, 0));
    endtask

    task automatic clk_step();
        exp_t e;
        logic ft_exp;
        @(posedge clk);
        #1;
        clkcnt++;
        ft_exp = 1'b0;
        if (clkcnt % 2 == 0) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            ft_exp = (mh == 0 && mv == VA);
            sb.push_back(expect_at(mh, mv));
            if (sb.size() == 3) begin
                e = sb.pop_front();
                check($sformatf("rgb(%0d,%0d)", e.h, e.v), 32'({r, g, b}), 32'(e.rgb));
                check($sformatf("hs(%0d,%0d)", e.h, e.v), 32'(hs), 32'(e.hs));
                check($sformatf("vs(%0d,%0d)", e.h, e.v), 32'(vs), 32'(e.vs));
                if (mode == 0 && e.h >= 8 && e.h <= 11 && e.v >= 4 && e.v <= 7)
                    check($sformatf("blk4x4(%0d,%0d)", e.h, e.v), 32'({r, g, b}), 32'h0A2);
                if (mode == 1 && !(e.h < HA && e.v < VA))
                    check($sformatf("blank(%0d,%0d)", e.h, e.v), 32'({r, g, b}), 32'd0);
            end
        end
        check($sformatf("frame_tick@%0d", clkcnt), 32'(frame_tick), 32'(ft_exp));
        if (frame_tick) begin
            ft_cnt++;
            check("ft_vs_high", 32'(vs), 32'd1);
            if (ft_ok)
                check("ft_spacing", clkcnt - ft_t, FRAME_CLK);
            ft_t = clkcnt;
            ft_ok = 1'b1;
        end
        if (prev_hs && !hs) begin
            if (hs_fall_ok)
                check("hs_period", clkcnt - hs_fall_t, 2 * HT);
            hs_fall_t = clkcnt;
            hs_fall_ok = 1'b1;
        end
        if (!prev_hs && hs && hs_fall_ok)
            check("hs_low", clkcnt - hs_fall_t, 2 * HSW);
        if (prev_vs && !vs) begin
            if (vs_fall_ok)
                check("vs_period", clkcnt - vs_fall_t, FRAME_CLK);
            vs_fall_t = clkcnt;
            vs_fall_ok = 1'b1;
        end
        if (!prev_vs && vs && vs_fall_ok)
            check("vs_low", clkcnt - vs_fall_t, 2 * HT * VSW);
        prev_hs = hs;
        prev_vs = vs;
    endtask

    initial begin
        logic found;

        // Reset state
        rst = 1'b0;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");

        // Free run with addr[7:0] framebuffer over three frames
        @(negedge clk);
        rst = 1'b1;
        sb_restart();
        repeat (3 * FRAME_CLK + 20) clk_step();
        check("ft_count_3frames", ft_cnt, 32'd3);

        // Mid-frame asynchronous reset at (h=30, v=10)
        found = 1'b0;
        for (int i = 0; i < int'(FRAME_CLK) && !found; i++) begin
            clk_step();
            if (clkcnt % 2 == 0 && mh == 30 && mv == 10)
                found = 1'b1;
        end
        check("seek_midframe", 32'(found), 32'd1);
        check("midframe_nonzero_rgb", 32'({r, g, b} != 8'h00), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async");
        mode = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("held");

        // All-white framebuffer: blanking must stay black; restart at (0,0)
        @(negedge clk);
        rst = 1'b1;
        sb_restart();
        check("restart_rgb", 32'({r, g, b}), 32'd0);
        repeat (FRAME_CLK + 20) clk_step();

        // All-black framebuffer (border colour shows when enabled)
        @(negedge clk);
        rst = 1'b0;
        mode = 2;
        @(negedge clk);
        rst = 1'b1;
        sb_restart();
        repeat (FRAME_CLK + 20) clk_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync widths in pixels (line total 800).
REQ-003 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, 10/2/33, vertical porch and sync widths in lines (frame total 525).
REQ-005 SHALL have parameter BORDER_COLOR, 8'hFF, RRRGGGBB colour for the border feature.
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-007 SHALL have port rst  input  1  reset; one clock, asynchronous and active-low.
REQ-008 SHALL have port fb_addr  output  15  framebuffer read address, 160x120 pixels, row-major.
REQ-009 SHALL have port fb_data  input  8  framebuffer read data (RRRGGGBB), valid 1 clk after fb_addr.
REQ-010 SHALL have ports r/g/b  output  3/3/2  VGA colour.
REQ-011 SHALL have ports hs/vs  output  1/1  VGA syncs, active-low.
REQ-012 SHALL have port frame_tick  output  1  one-clk pulse at start of vertical blanking, for the CPU.

Function
REQ-013 SHALL toggle pix_ph every clk; pix_en = (pix_ph==1), giving a 25 MHz pixel rate.
REQ-014 SHALL count hcnt 0..799 on pix_en; on 799 it wraps to 0 and advances vcnt 0..524, which wraps 524->0.
REQ-015 SHALL define active = (hcnt<640)&&(vcnt<480); hs_raw low for hcnt 656..751; vs_raw low for vcnt 490..491.
REQ-016 Stage 1, on pix_en: fb_addr <= (vcnt>>2)*160 + (hcnt>>2) when active, else hold its value. Register active_d, hs_d and vs_d.
REQ-017 SHALL implement the multiply by 160 as (y<<7)+(y<<5), without a multiplier; the result fits 15 bits (max 19199).
REQ-018 Stage 2, on the next pix_en: {r,g,b} <= active_d ? fb_data : 0, hs <= hs_d, vs <= vs_d.
REQ-019 Colour, hs and vs SHALL all lag the counters by exactly 2 pixel periods (4 clk), so colour stays aligned with the syncs.
REQ-020 SHALL replicate each framebuffer pixel over a 4x4 block of screen pixels.
REQ-021 SHALL pulse frame_tick high for exactly one clk on the pix_en where vcnt goes 479->480; it is not pulsed at any other time.
REQ-022 SHALL never drive non-zero colour while active_d==0, including during porches and sync.

Reset
REQ-023 While rst==0: pix_ph=0, hcnt=0, vcnt=0, fb_addr=0, r=g=b=0, hs=1, vs=1, frame_tick=0, and all pipeline registers cleared.
REQ-024 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clk edge.
REQ-025 After release, the first pix_en SHALL occur on the 2nd rising clk edge, and the frame restarts at (0,0).

Configuration
REQ-026 With macro VGA_BORDER_EN defined, stage 2 SHALL output BORDER_COLOR instead of fb_data where the framebuffer coordinate x is 0 or 159, or y is 0 or 119.
REQ-027 With VGA_BORDER_EN undefined, no border logic SHALL exist and the output is purely fb_data.

Structure
REQ-028 Package vga_pkg SHALL hold the timing constants (totals, sync start/end), FB_W=160, FB_H=120 and the rgb332 typedef.
REQ-029 Sub-module vga_timing SHALL contain pix_ph, hcnt, vcnt, active, hs_raw, vs_raw and the frame_tick decode; vga_ctrl holds the fetch/output pipeline.

Verification
REQ-030 Free-run after reset -> hs period 1600 clk with low time 192 clk; vs period 840000 clk with low time 3200 clk.
REQ-031 Framebuffer model returns addr[7:0] -> screen pixel (x=8,y=4) shows {r,g,b}=8'hA2 (addr 162); pixels (8..11, 4..7) are identical.
REQ-032 Count frame_tick over 3 frames -> exactly 3 one-clk pulses, 840000 clk apart, with vs still high at each pulse.
REQ-033 Model returns 8'hFF everywhere -> colour is 0 for all hcnt>=640 or vcnt>=480, observed 4 clk later at the outputs.
REQ-034 Assert rst at vcnt=300 mid-line -> outputs reach reset values within the same clk, and the next frame starts at hcnt=vcnt=0.
REQ-035 With VGA_BORDER_EN defined and the model returning 8'h00 -> screen rows 0..3 and columns 636..639 show 8'hFF, and pixel (320,240) shows 8'h00.
